udp_agg_engine: RTL and testbench

Parametrised packet aggregation engine for the 40 Gbps UDP parser. It accepts a packet as a stream of wide beats and reduces the payload words to a single result. The supported reductions are SUM, MAX, MIN or COUNT, selected by a per-packet opcode. Completed results are queued in a small result FIFO, so the input can run back-to-back while downstream back-pressures. It sits between the beat-aligned UDP receive path and the result writer.

---
 rtl/udp_agg_pkg.sv | 32 +++
 rtl/udp_agg_lane_reduce.sv | 74 +++++++
 rtl/udp_agg_engine.sv | 219 +++++++++++++++++++++
 tb/tb_udp_agg_engine.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_agg_pkg.sv
// Shared types and field positions for the UDP aggregation engine.
package udp_agg_pkg;

  typedef enum logic [15:0] {
    OP_SUM   = 16'd1,
    OP_MAX   = 16'd2,
    OP_MIN   = 16'd3,
    OP_COUNT = 16'd4
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    OPC,
    BODY
  } rx_state_e;

  localparam int unsigned OPC_LSB       = 160;
  localparam int unsigned OPC_W         = 16;
  localparam int unsigned BEAT1_LANES   = 5;
  localparam int unsigned REC_W         = 64;
  localparam int unsigned REC_OPC_LSB   = 32;
  localparam int unsigned REC_ERR_BIT   = 48;
  localparam int unsigned REC_OVF_BIT   = 49;
  localparam int unsigned REC_BEATS_LSB = 50;
  localparam int unsigned BEATS_W       = 14;

  // Beat counter increment that sticks at all-ones.
  function automatic logic [BEATS_W-1:0] sat_inc(input logic [BEATS_W-1:0] v);
    return (&v) ? v : v + BEATS_W'(1);
  endfunction

endpackage

// File: rtl/udp_agg_lane_reduce.sv
// Per-beat reduction of the masked payload lanes, one register stage.
module udp_agg_lane_reduce
  import udp_agg_pkg::*;
#(
  parameter int unsigned DATA_W = 256,
  parameter int unsigned WORD_W = 32,
  parameter int unsigned ACC_W  = 32
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      en,
  input  logic [DATA_W/WORD_W-1:0]                  mask,
  input  logic [OPC_W-1:0]                          op,
  input  logic [DATA_W-1:0]                         data,
  output logic [ACC_W-1:0]                          part_q,
  output logic                                      carry_q,
  output logic [$clog2(DATA_W/WORD_W+1)-1:0]        cnt_q
);

  localparam int unsigned LANES = DATA_W / WORD_W;
  localparam int unsigned CNT_W = $clog2(LANES + 1);
  localparam int unsigned SUM_W = ACC_W + $clog2(LANES);

  logic [SUM_W-1:0] sum;
  logic [ACC_W-1:0] mx, mn, w, part;
  logic [CNT_W-1:0] n;
  logic             carry;

  always_comb begin
    sum = '0;
    mx  = '0;
    mn  = '1;
    n   = '0;
    w   = '0;
    for (int i = 0; i < LANES; i++) begin
      w = ACC_W'(data[i*WORD_W +: WORD_W]);
      if (mask[i]) begin
        sum = sum + SUM_W'(w);
        if (w > mx) mx = w;
        if (w < mn) mn = w;
        n = n + CNT_W'(1);
      end
    end
  end

  // An empty MIN beat yields all-ones so it never wins the later compare.
  always_comb begin
    part  = '0;
    carry = 1'b0;
    case (op)
      OP_SUM: begin
        part  = sum[ACC_W-1:0];
        carry = |sum[SUM_W-1:ACC_W];
      end
      OP_MAX:   part = mx;
      OP_MIN:   part = mn;
      OP_COUNT: part = ACC_W'(n);
      default:  part = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      part_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else if (en) begin
      part_q  <= part;
      carry_q <= carry;
      cnt_q   <= n;
    end
  end

endmodule

// File: rtl/udp_agg_engine.sv
// Packet aggregation engine: receive FSM, lane reduce, accumulate, credit-guarded result FIFO.
module udp_agg_engine
  import udp_agg_pkg::*;
#(
  parameter int unsigned DATA_W    = 256,
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned ACC_W     = 32,
  parameter int unsigned RES_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_W-1:0]          In_data,
  input  logic [DATA_W/WORD_W-1:0]   In_keep,
  input  logic                       In_last,
  input  logic                       In_valid,
  output logic                       In_ready,
  output logic [DATA_W-1:0]          Out_data,
  output logic                       Out_valid,
  input  logic                       Out_ready
);

  localparam int unsigned LANES = DATA_W / WORD_W;
  localparam int unsigned CNT_W = $clog2(LANES + 1);
  localparam int unsigned PTR_W = $clog2(RES_DEPTH);
  localparam int unsigned OCC_W = PTR_W + 2;
  localparam logic [LANES-1:0] B1_MASK = LANES'({BEAT1_LANES{1'b1}});

  rx_state_e          state;
  logic [OPC_W-1:0]   op_q, op_cur;
  logic [BEATS_W-1:0] beat_cnt, beats_inc;
  logic [LANES-1:0]   mask_cur;
  logic               accept;

  logic               s1_vld, s1_first, s1_last, s1_herr;
  logic [OPC_W-1:0]   s1_op;
  logic [BEATS_W-1:0] s1_beats;
  logic [ACC_W-1:0]   lr_part;
  logic               lr_carry;
  logic [CNT_W-1:0]   lr_cnt;

  assign accept    = In_valid && In_ready;
  assign op_cur    = (state == OPC) ? In_data[OPC_LSB +: OPC_W] : op_q;
  assign mask_cur  = (state == OPC) ? (In_keep & B1_MASK) : In_keep;
  assign beats_inc = (state == IDLE) ? BEATS_W'(1) : sat_inc(beat_cnt);

  // Receive FSM plus the stage-1 control that travels alongside the lane reduce.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      op_q     <= '0;
      beat_cnt <= '0;
      s1_vld   <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_herr  <= 1'b0;
      s1_op    <= '0;
      s1_beats <= '0;
    end else begin
      s1_vld <= accept && ((state != IDLE) || In_last);
      if (accept) begin
        beat_cnt <= beats_inc;
        s1_first <= (state == OPC);
        s1_last  <= In_last;
        s1_herr  <= (state == IDLE);
        s1_op    <= op_cur;
        s1_beats <= beats_inc;
        case (state)
          IDLE: state <= In_last ? IDLE : OPC;
          OPC: begin
            op_q  <= op_cur;
            state <= In_last ? IDLE : BODY;
          end
          default: if (In_last) state <= IDLE;
        endcase
      end
    end
  end

  udp_agg_lane_reduce #(
    .DATA_W (DATA_W),
    .WORD_W (WORD_W),
    .ACC_W  (ACC_W)
  ) u_lane_reduce (
    .clk     (clk),
    .reset   (reset),
    .en      (accept),
    .mask    (mask_cur),
    .op      (op_cur),
    .data    (In_data),
    .part_q  (lr_part),
    .carry_q (lr_carry),
    .cnt_q   (lr_cnt)
  );

  logic [ACC_W-1:0]   acc_q;
  logic [ACC_W:0]     sum2;
  logic               ovf_q, any_q, herr_q, done_q;
  logic [OPC_W-1:0]   op2_q;
  logic [BEATS_W-1:0] beats2_q;

  assign sum2 = {1'b0, acc_q} + {1'b0, lr_part};

  // Stage 2: fold each beat partial into the packet accumulator.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      any_q    <= 1'b0;
      herr_q   <= 1'b0;
      op2_q    <= '0;
      beats2_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= s1_vld && s1_last;
      if (s1_vld) begin
        beats2_q <= s1_beats;
        herr_q   <= s1_herr;
        if (s1_herr) begin
          acc_q <= '0;
          ovf_q <= 1'b0;
          any_q <= 1'b0;
          op2_q <= '0;
        end else if (s1_first) begin
          acc_q <= lr_part;
          ovf_q <= lr_carry;
          any_q <= (lr_cnt != '0);
          op2_q <= s1_op;
        end else begin
          any_q <= any_q || (lr_cnt != '0);
          case (op2_q)
            OP_SUM: begin
              acc_q <= sum2[ACC_W-1:0];
              ovf_q <= ovf_q | sum2[ACC_W] | lr_carry;
            end
            OP_MAX:   if (lr_part > acc_q) acc_q <= lr_part;
            OP_MIN:   if (lr_part < acc_q) acc_q <= lr_part;
            OP_COUNT: acc_q <= sum2[ACC_W-1:0];
            default:  acc_q <= acc_q;
          endcase
        end
      end
    end
  end

  logic [ACC_W-1:0] res;
  logic             res_err, res_ovf;
  logic [REC_W-1:0] rec_n, rec_q;
  logic             rec_vld;

  always_comb begin
    res     = '0;
    res_err = 1'b0;
    res_ovf = 1'b0;
    if (herr_q) begin
      res_err = 1'b1;
    end else begin
      case (op2_q)
        OP_SUM: begin
          res     = acc_q;
          res_ovf = ovf_q;
        end
        OP_MAX, OP_COUNT: res = acc_q;
        OP_MIN: begin
          res     = any_q ? acc_q : '0;
          res_err = !any_q;
        end
        default: res_err = 1'b1;
      endcase
    end
    rec_n                              = '0;
    rec_n[ACC_W-1:0]                   = res;
    rec_n[REC_OPC_LSB +: OPC_W]        = op2_q;
    rec_n[REC_ERR_BIT]                 = res_err;
    rec_n[REC_OVF_BIT]                 = res_ovf;
    rec_n[REC_BEATS_LSB +: BEATS_W]    = beats2_q;
  end

  logic [REC_W-1:0] mem [RES_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [OCC_W-1:0] fifo_cnt, inflight, fifo_cnt_n, inflight_n;
  logic             push, pop;

  assign push = rec_vld;
  assign pop  = Out_valid && Out_ready;

  always_comb begin
    fifo_cnt_n = fifo_cnt + OCC_W'(push) - OCC_W'(pop);
    inflight_n = inflight + OCC_W'(accept && In_last) - OCC_W'(push);
  end

  // Stage 3 record register, FIFO write, and credit-derived handshakes.
  always_ff @(posedge clk) begin
    if (reset) begin
      rec_q     <= '0;
      rec_vld   <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_cnt  <= '0;
      inflight  <= '0;
      Out_valid <= 1'b0;
      In_ready  <= 1'b1;
    end else begin
      rec_vld <= done_q;
      if (done_q) rec_q <= rec_n;
      if (push) begin
        mem[wr_ptr] <= rec_q;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_cnt  <= fifo_cnt_n;
      inflight  <= inflight_n;
      Out_valid <= (fifo_cnt_n != '0);
      In_ready  <= (fifo_cnt_n + inflight_n) < OCC_W'(RES_DEPTH);
    end
  end

  assign Out_data = Out_valid ? DATA_W'(mem[rd_ptr]) : '0;

endmodule

// File: tb/tb_udp_agg_engine.sv
// Directed bench for udp_agg_engine with hand-computed result records.
module tb_udp_agg_engine;

  logic         clk = 1'b0;
  logic         reset;
  logic [255:0] In_data;
  logic [7:0]   In_keep;
  logic         In_last, In_valid, In_ready;
  logic [255:0] Out_data;
  logic         Out_valid, Out_ready;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  udp_agg_engine #(
    .DATA_W    (256),
    .WORD_W    (32),
    .ACC_W     (32),
    .RES_DEPTH (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .In_data   (In_data),
    .In_keep   (In_keep),
    .In_last   (In_last),
    .In_valid  (In_valid),
    .In_ready  (In_ready),
    .Out_data  (Out_data),
    .Out_valid (Out_valid),
    .Out_ready (Out_ready)
  );

  function automatic logic [255:0] rec(input logic [31:0] res, input logic [15:0] op,
                                       input logic err, input logic ovf, input logic [13:0] beats);
    logic [255:0] r;
    r        = '0;
    r[31:0]  = res;
    r[47:32] = op;
    r[48]    = err;
    r[49]    = ovf;
    r[63:50] = beats;
    return r;
  endfunction

  function automatic logic [255:0] fill(input logic [31:0] w);
    logic [255:0] d;
    d = '0;
    for (int i = 0; i < 8; i++) d[i*32 +: 32] = w;
    return d;
  endfunction

  // Beat 1: five payload words, opcode, and header junk in the upper lanes.
  function automatic logic [255:0] mk_b1(input logic [15:0] op, input logic [31:0] w0,
                                         input logic [31:0] w1, input logic [31:0] w2,
                                         input logic [31:0] w3, input logic [31:0] w4);
    logic [255:0] d;
    d          = '0;
    d[31:0]    = w0;
    d[63:32]   = w1;
    d[95:64]   = w2;
    d[127:96]  = w3;
    d[159:128] = w4;
    d[175:160] = op;
    d[191:176] = 16'hABCD;
    d[223:192] = 32'hDEAD_BEEF;
    d[255:224] = 32'hFFFF_FFF0;
    return d;
  endfunction

  task automatic send_beat(input logic [255:0] d, input logic [7:0] k, input logic l);
    int guard;
    guard    = 0;
    In_data  = d;
    In_keep  = k;
    In_last  = l;
    In_valid = 1'b1;
    while (!In_ready && guard < 300) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!In_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: In_ready=%b required 1", In_ready);
    end
    @(posedge clk); #1;
    In_valid = 1'b0;
    In_last  = 1'b0;
  endtask

  task automatic pop_result(output logic [255:0] d);
    int guard;
    guard = 0;
    while (!Out_valid && guard < 300) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!Out_valid) begin
      d = 'x;
    end else begin
      d = Out_data;
      Out_ready = 1'b1;
      @(posedge clk); #1;
      Out_ready = 1'b0;
    end
  endtask

  task automatic send_pkt4(input logic [15:0] op);
    send_beat(fill(32'h4500_0054), 8'hFF, 1'b0);
    send_beat(mk_b1(op, 1, 2, 3, 4, 5), 8'hFF, 1'b0);
    send_beat(fill(10), 8'hFF, 1'b0);
    send_beat(fill(7), 8'h0F, 1'b1);
  endtask

  task automatic test_reset;
    @(posedge clk); #1;
    total++;
    if (In_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", In_ready); end
    total++;
    if (Out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", Out_valid); end
    total++;
    if (Out_data !== 256'd0) begin bad++; $display("FAIL reset_out_data: got %h want 0", Out_data); end
  endtask

  task automatic test_sum;
    logic [255:0] exp, d;
    exp = rec(32'd123, 16'd1, 1'b0, 1'b0, 14'd4);
    send_pkt4(16'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++;
    if (Out_valid !== 1'b0) begin bad++; $display("FAIL sum_latency_early: Out_valid=%b want 0", Out_valid); end
    @(posedge clk); #1;
    total++;
    if (Out_valid !== 1'b1) begin bad++; $display("FAIL sum_latency_3: Out_valid=%b want 1", Out_valid); end
    total++;
    if (Out_data !== exp) begin bad++; $display("FAIL sum_data: got %h want %h", Out_data[63:0], exp[63:0]); end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (Out_data !== exp || Out_valid !== 1'b1) begin
      bad++; $display("FAIL sum_hold: got %h v=%b want %h", Out_data[63:0], Out_valid, exp[63:0]);
    end
    pop_result(d);
    total++;
    if (Out_valid !== 1'b0) begin bad++; $display("FAIL sum_popped: Out_valid=%b want 0", Out_valid); end
  endtask

  task automatic test_max_min_count;
    logic [15:0]  ops [3];
    logic [31:0]  exps [3];
    logic [255:0] d, exp;
    ops  = '{16'd2, 16'd3, 16'd4};
    exps = '{32'd10, 32'd1, 32'd17};
    for (int i = 0; i < 3; i++) begin
      send_pkt4(ops[i]);
      pop_result(d);
      exp = rec(exps[i], ops[i], 1'b0, 1'b0, 14'd4);
      total++;
      if (d !== exp) begin bad++; $display("FAIL reduce_op%0d: got %h want %h", ops[i], d[63:0], exp[63:0]); end
    end
  endtask

  task automatic test_empty_and_hdr_err;
    logic [255:0] d, exp;
    send_beat(mk_b1(16'd3, 9, 9, 9, 9, 9), 8'hFF, 1'b1);
    pop_result(d);
    exp = rec(32'd0, 16'd0, 1'b1, 1'b0, 14'd1);
    total++;
    if (d !== exp) begin bad++; $display("FAIL hdr_last: got %h want %h", d[63:0], exp[63:0]); end
    send_beat(fill(1), 8'hFF, 1'b0);
    send_beat(mk_b1(16'd3, 9, 9, 9, 9, 9), 8'h00, 1'b1);
    pop_result(d);
    exp = rec(32'd0, 16'd3, 1'b1, 1'b0, 14'd2);
    total++;
    if (d !== exp) begin bad++; $display("FAIL min_empty: got %h want %h", d[63:0], exp[63:0]); end
    send_beat(fill(1), 8'hFF, 1'b0);
    send_beat(mk_b1(16'd2, 9, 9, 9, 9, 9), 8'h00, 1'b1);
    pop_result(d);
    exp = rec(32'd0, 16'd2, 1'b0, 1'b0, 14'd2);
    total++;
    if (d !== exp) begin bad++; $display("FAIL max_empty: got %h want %h", d[63:0], exp[63:0]); end
  endtask

  task automatic test_overflow;
    logic [255:0] d, exp;
    send_beat(fill(32'h1111_1111), 8'hFF, 1'b0);
    send_beat(mk_b1(16'd1, 32'hFFFF_FFFF, 32'd2, 32'd5, 32'd5, 32'd5), 8'h03, 1'b1);
    pop_result(d);
    exp = rec(32'd1, 16'd1, 1'b0, 1'b1, 14'd2);
    total++;
    if (d !== exp) begin bad++; $display("FAIL sum_overflow: got %h want %h", d[63:0], exp[63:0]); end
  endtask

  task automatic test_bad_opcode;
    logic [255:0] d, exp;
    send_beat(fill(32'h2222_2222), 8'hFF, 1'b0);
    send_beat(mk_b1(16'd7, 1, 2, 3, 4, 5), 8'hFF, 1'b0);
    send_beat(fill(3), 8'hFF, 1'b0);
    send_beat(fill(3), 8'hFF, 1'b1);
    send_pkt4(16'd1);
    pop_result(d);
    exp = rec(32'd0, 16'd7, 1'b1, 1'b0, 14'd4);
    total++;
    if (d !== exp) begin bad++; $display("FAIL bad_opcode: got %h want %h", d[63:0], exp[63:0]); end
    pop_result(d);
    exp = rec(32'd123, 16'd1, 1'b0, 1'b0, 14'd4);
    total++;
    if (d !== exp) begin bad++; $display("FAIL after_bad_opcode: got %h want %h", d[63:0], exp[63:0]); end
  endtask

  task automatic test_back_to_back;
    Out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send_beat(fill(32'h3333_3333), 8'hFF, 1'b0);
      send_beat(mk_b1(16'd1, 32'(i + 1), 0, 0, 0, 0), 8'h01, 1'b0);
      send_beat(fill(100), 8'h01, 1'b1);
    end
    In_data  = fill(32'h3333_3333);
    In_keep  = 8'hFF;
    In_last  = 1'b0;
    In_valid = 1'b1;
    total++;
    if (In_ready !== 1'b0) begin bad++; $display("FAIL full_ready_drop: In_ready=%b want 0", In_ready); end
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (In_ready !== 1'b0 || Out_valid !== 1'b1) begin
      bad++; $display("FAIL full_hold: In_ready=%b Out_valid=%b want 0/1", In_ready, Out_valid);
    end
    fork
      begin
        for (int i = 4; i < 6; i++) begin
          send_beat(fill(32'h3333_3333), 8'hFF, 1'b0);
          send_beat(mk_b1(16'd1, 32'(i + 1), 0, 0, 0, 0), 8'h01, 1'b0);
          send_beat(fill(100), 8'h01, 1'b1);
        end
      end
      begin
        logic [255:0] d, exp;
        for (int j = 0; j < 6; j++) begin
          pop_result(d);
          exp = rec(32'(j + 101), 16'd1, 1'b0, 1'b0, 14'd3);
          total++;
          if (d !== exp) begin bad++; $display("FAIL drain_%0d: got %h want %h", j, d[63:0], exp[63:0]); end
        end
      end
    join
    total++;
    if (In_ready !== 1'b1 || Out_valid !== 1'b0) begin
      bad++; $display("FAIL drained: In_ready=%b Out_valid=%b want 1/0", In_ready, Out_valid);
    end
  endtask

  task automatic test_reset_mid_body;
    logic [255:0] d, exp;
    send_pkt4(16'd4);
    repeat (4) @(posedge clk);
    #1;
    send_beat(fill(32'h4444_4444), 8'hFF, 1'b0);
    send_beat(mk_b1(16'd1, 50, 50, 50, 50, 50), 8'hFF, 1'b0);
    send_beat(fill(60), 8'hFF, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    total++;
    if (Out_valid !== 1'b0 || Out_data !== 256'd0) begin
      bad++; $display("FAIL mid_reset_out: Out_valid=%b Out_data=%h want 0/0", Out_valid, Out_data[63:0]);
    end
    total++;
    if (In_ready !== 1'b1) begin bad++; $display("FAIL mid_reset_ready: In_ready=%b want 1", In_ready); end
    send_pkt4(16'd1);
    pop_result(d);
    exp = rec(32'd123, 16'd1, 1'b0, 1'b0, 14'd4);
    total++;
    if (d !== exp) begin bad++; $display("FAIL post_reset_sum: got %h want %h", d[63:0], exp[63:0]); end
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (Out_valid !== 1'b0) begin bad++; $display("FAIL post_reset_extra: Out_valid=%b want 0", Out_valid); end
  endtask

  initial begin
    In_valid  = 1'b0;
    In_data   = '0;
    In_keep   = '0;
    In_last   = 1'b0;
    Out_ready = 1'b0;
    reset     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    test_reset;
    test_sum;
    test_max_min_count;
    test_empty_and_hdr_err;
    test_overflow;
    test_bad_opcode;
    test_back_to_back;
    test_reset_mid_body;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
